pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: drives PC write enable, fetch-to-decode hold/flush, decode-to-execute bubble insertion, and global freeze during data-memory wait.
- Detects load-use hazards between decode and the decode-to-execute register outputs.
- Sequences multi-cycle branch redirect flushes.
- Watches data-memory stalls with a timeout.

Parameters:
- FLUSH_CYCLES, 1, cycles fetch-to-decode and decode-to-execute are flushed per taken branch; legal range 1..15.
- MEM_TIMEOUT, 255, consecutive memoryBusy cycles after which memoryTimeout sets; legal range 1..65535.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- decodeRs1  in  5  rs1 of instruction in decode
- decodeRs2  in  5  rs2 of instruction in decode
- decodeUsesRs1  in  1  decode instruction reads rs1
- decodeUsesRs2  in  1  decode instruction reads rs2
- executeRd  in  5  rdOut of decode-to-execute register
- executeMemoryReadEnable  in  1  memoryReadEnableOut of decode-to-execute register (load in execute)
- branchTaken  in  1  execute resolved a taken branch/jump; held by execute while frozen
- memoryBusy  in  1  data memory not ready this cycle
- pcWriteEnable  out  1  PC may update
- fetchDecodeWriteEnable  out  1  fetch-to-decode register may load
- fetchDecodeFlush  out  1  fetch-to-decode register loads NOP/zero
- decodeExecuteFlush  out  1  decode-to-execute register loads zero (bubble)
- backEndWriteEnable  out  1  decode-to-execute and later registers may load
- controllerState  out  2  0=RUN, 1=MEM_WAIT, 2=FLUSH
- memoryTimeout  out  1  sticky: memory stall exceeded MEM_TIMEOUT

Behaviour:
- loadUse = executeMemoryReadEnable && executeRd != 0 && ((decodeUsesRs1 && decodeRs1 == executeRd) || (decodeUsesRs2 && decodeRs2 == executeRd)).
- All control outputs are combinational from state and inputs, so hazards act in the same cycle. State, counters and the sticky flag are registered.
- Priority, highest first: reset > memoryBusy > branchTaken / FLUSH > loadUse > normal.
- Reset high:
  - Next state RUN; flushCounter=0; busyCounter=0; memoryTimeout=0.
  - Outputs during reset: pcWriteEnable=0, fetchDecodeWriteEnable=0, backEndWriteEnable=0, fetchDecodeFlush=1, decodeExecuteFlush=1.
  - Reset mid-stall or mid-flush aborts immediately.
- Freeze (memoryBusy=1, any state):
  - All write enables 0; both flushes 0.
  - Next state MEM_WAIT, or stays FLUSH if already in FLUSH; flushCounter holds.
  - busyCounter increments, saturating at MEM_TIMEOUT.
  - When busyCounter reaches MEM_TIMEOUT, memoryTimeout sets on that edge and stays set until reset.
- memoryBusy=0: busyCounter clears.
- MEM_WAIT with memoryBusy=0: evaluate exactly as RUN in the same cycle. Next state follows RUN rules (a pending branchTaken is seen now).
- RUN, branchTaken=1:
  - pcWriteEnable=1, fetchDecodeWriteEnable=1, fetchDecodeFlush=1, decodeExecuteFlush=1, backEndWriteEnable=1.
  - If FLUSH_CYCLES>1: next state FLUSH, flushCounter=FLUSH_CYCLES-1. Otherwise stay RUN.
  - loadUse is ignored this cycle.
- FLUSH, memoryBusy=0:
  - Same outputs as the branch cycle; flushCounter decrements.
  - When flushCounter==1 the next state is RUN.
  - A new branchTaken in FLUSH reloads flushCounter=FLUSH_CYCLES-1.
- RUN, loadUse=1 (no busy, no branch):
  - pcWriteEnable=0, fetchDecodeWriteEnable=0, decodeExecuteFlush=1, backEndWriteEnable=1.
  - Exactly one bubble. The next cycle the load has advanced, so no repeat stall.
- RUN, no event: all write enables 1, flushes 0.
- controllerState reflects the registered state.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs stallCycles [31:0], flushCount [31:0], bubbleCount [31:0], all reset to 0 and wrapping modulo 2^32.
  - stallCycles increments each memoryBusy cycle.
  - flushCount increments once per accepted branchTaken.
  - bubbleCount increments once per loadUse bubble.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load x5 in execute (executeMemoryReadEnable=1, executeRd=5), decode uses rs1=5 -> one cycle of pcWriteEnable=0, fetchDecodeWriteEnable=0, decodeExecuteFlush=1; next cycle all enables 1. Repeat with executeRd=0 -> no stall.
- branchTaken pulse with FLUSH_CYCLES=3 -> fetchDecodeFlush=1 and decodeExecuteFlush=1 for exactly 3 cycles; controllerState 0,2,2,0.
- memoryBusy for 4 cycles with branchTaken held -> all enables 0 for 4 cycles, controllerState=1; cycle 5 performs the branch flush.
- memoryBusy held 255 cycles with MEM_TIMEOUT=255 -> memoryTimeout=1 after the 255th edge; stays 1 after busy drops; clears only on reset.
- Reset asserted mid-FLUSH (flushCounter=2) -> next cycle controllerState=0, memoryTimeout=0; during reset both flushes 1 and all enables 0.
- HAZARD_PERF_COUNTERS_EN defined: 2 bubbles, 1 branch, 3 busy cycles -> bubbleCount=2, flushCount=1, stallCycles=3.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch redirect flushes, memory freeze with timeout.
// Optional HAZARD_PERF_COUNTERS_EN adds stallCycles/flushCount/bubbleCount event counters.
module pipeline_hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  decodeRs1,
  input  logic [4:0]  decodeRs2,
  input  logic        decodeUsesRs1,
  input  logic        decodeUsesRs2,
  input  logic [4:0]  executeRd,
  input  logic        executeMemoryReadEnable,
  input  logic        branchTaken,
  input  logic        memoryBusy,
  output logic        pcWriteEnable,
  output logic        fetchDecodeWriteEnable,
  output logic        fetchDecodeFlush,
  output logic        decodeExecuteFlush,
  output logic        backEndWriteEnable,
  output logic [1:0]  controllerState,
  output logic        memoryTimeout
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stallCycles,
  output logic [31:0] flushCount,
  output logic [31:0] bubbleCount
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_MAX  = 16'(MEM_TIMEOUT);
  localparam logic [15:0] TIMEOUT_PRE  = 16'(MEM_TIMEOUT - 1);

  logic [1:0]  state, state_n;
  logic [3:0]  flush_cnt, flush_cnt_n;
  logic [15:0] busy_cnt;
  logic        timeout_q;
  logic        load_use;
  logic        in_flush;
  logic        redirect;
  logic        bubble;

  assign load_use = executeMemoryReadEnable && (executeRd != 5'd0) &&
                    ((decodeUsesRs1 && (decodeRs1 == executeRd)) ||
                     (decodeUsesRs2 && (decodeRs2 == executeRd)));

  // MEM_WAIT with memory ready behaves as RUN, so only FLUSH needs distinguishing.
  assign in_flush = (state == FLUSH);
  assign redirect = !memoryBusy && (branchTaken || in_flush);
  assign bubble   = !memoryBusy && !branchTaken && !in_flush && load_use;

  always_comb begin
    pcWriteEnable          = 1'b1;
    fetchDecodeWriteEnable = 1'b1;
    fetchDecodeFlush       = 1'b0;
    decodeExecuteFlush     = 1'b0;
    backEndWriteEnable     = 1'b1;
    if (reset) begin
      pcWriteEnable          = 1'b0;
      fetchDecodeWriteEnable = 1'b0;
      backEndWriteEnable     = 1'b0;
      fetchDecodeFlush       = 1'b1;
      decodeExecuteFlush     = 1'b1;
    end else if (memoryBusy) begin
      pcWriteEnable          = 1'b0;
      fetchDecodeWriteEnable = 1'b0;
      backEndWriteEnable     = 1'b0;
    end else if (redirect) begin
      fetchDecodeFlush       = 1'b1;
      decodeExecuteFlush     = 1'b1;
    end else if (bubble) begin
      pcWriteEnable          = 1'b0;
      fetchDecodeWriteEnable = 1'b0;
      decodeExecuteFlush     = 1'b1;
    end
  end

  always_comb begin
    state_n     = RUN;
    flush_cnt_n = flush_cnt;
    if (memoryBusy) begin
      state_n = in_flush ? FLUSH : MEM_WAIT;
    end else if (branchTaken) begin
      // A branch seen while already flushing restarts the full flush window.
      if (FLUSH_CYCLES > 1) begin
        state_n     = FLUSH;
        flush_cnt_n = FLUSH_RELOAD;
      end else begin
        state_n     = RUN;
        flush_cnt_n = 4'd0;
      end
    end else if (in_flush) begin
      flush_cnt_n = flush_cnt - 4'd1;
      state_n     = (flush_cnt == 4'd1) ? RUN : FLUSH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
      busy_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      if (memoryBusy) begin
        if (busy_cnt != TIMEOUT_MAX) busy_cnt <= busy_cnt + 16'd1;
        // Sets on the edge where the counter lands on MEM_TIMEOUT.
        if (busy_cnt >= TIMEOUT_PRE) timeout_q <= 1'b1;
      end else begin
        busy_cnt <= 16'd0;
      end
    end
  end

  assign controllerState = state;
  assign memoryTimeout   = timeout_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCycles <= 32'd0;
      flushCount  <= 32'd0;
      bubbleCount <= 32'd0;
    end else begin
      if (memoryBusy)                  stallCycles <= stallCycles + 32'd1;
      if (!memoryBusy && branchTaken)  flushCount  <= flushCount + 32'd1;
      if (bubble)                      bubbleCount <= bubbleCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  decodeRs1, decodeRs2, executeRd;
  logic        decodeUsesRs1, decodeUsesRs2, executeMemoryReadEnable;
  logic        branchTaken, memoryBusy;
  logic        pcWriteEnable, fetchDecodeWriteEnable, fetchDecodeFlush;
  logic        decodeExecuteFlush, backEndWriteEnable, memoryTimeout;
  logic [1:0]  controllerState;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stallCycles, flushCount, bubbleCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(255)) dut (
    .clock(clock), .reset(reset),
    .decodeRs1(decodeRs1), .decodeRs2(decodeRs2),
    .decodeUsesRs1(decodeUsesRs1), .decodeUsesRs2(decodeUsesRs2),
    .executeRd(executeRd), .executeMemoryReadEnable(executeMemoryReadEnable),
    .branchTaken(branchTaken), .memoryBusy(memoryBusy),
    .pcWriteEnable(pcWriteEnable), .fetchDecodeWriteEnable(fetchDecodeWriteEnable),
    .fetchDecodeFlush(fetchDecodeFlush), .decodeExecuteFlush(decodeExecuteFlush),
    .backEndWriteEnable(backEndWriteEnable), .controllerState(controllerState),
    .memoryTimeout(memoryTimeout)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stallCycles(stallCycles), .flushCount(flushCount), .bubbleCount(bubbleCount)
`endif
  );

  // {pcWE, fdWE, fdFlush, deFlush, beWE}
  logic [4:0] outs;
  assign outs = {pcWriteEnable, fetchDecodeWriteEnable, fetchDecodeFlush,
                 decodeExecuteFlush, backEndWriteEnable};

  localparam logic [4:0] NORM  = 5'b11001;
  localparam logic [4:0] STALL = 5'b00011;
  localparam logic [4:0] FRZ   = 5'b00000;
  localparam logic [4:0] FLS   = 5'b11111;
  localparam logic [4:0] RST   = 5'b00110;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] erd;
    logic       emre, br, busy;
    logic [4:0] exp_out;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] erd, input logic emre,
                       input logic br, input logic busy);
    decodeRs1 = rs1; decodeRs2 = rs2; decodeUsesRs1 = u1; decodeUsesRs2 = u2;
    executeRd = erd; executeMemoryReadEnable = emre; branchTaken = br; memoryBusy = busy;
  endtask

  // Check outputs and state mid-cycle, then advance one edge.
  task automatic cyc(input string nm, input logic [4:0] eo, input logic [1:0] es);
    @(negedge clock);
    chk({nm, "_out"}, 32'(outs), 32'(eo));
    chk({nm, "_st"}, 32'(controllerState), 32'(es));
    tick();
  endtask

  initial begin
    vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, NORM,  2'd0};
    vecs[1]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, STALL, 2'd0};
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, NORM,  2'd0};
    vecs[3]  = '{5'd4, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, STALL, 2'd0};
    vecs[4]  = '{5'd4, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, NORM,  2'd0};
    vecs[5]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, NORM,  2'd0};
    vecs[6]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, FRZ,   2'd0};
    vecs[7]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, STALL, 2'd1};
    vecs[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, NORM,  2'd0};
    vecs[9]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, FRZ,   2'd0};
    vecs[10] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, FLS,   2'd1};
    vecs[11] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, FLS,   2'd2};
    vecs[12] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, FRZ,   2'd2};
    vecs[13] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, FLS,   2'd2};
    vecs[14] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, STALL, 2'd0};
    vecs[15] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, NORM,  2'd0};

    // Reset behaviour
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clock);
    chk("rst_out", 32'(outs), 32'(RST));
    chk("rst_st", 32'(controllerState), 32'd0);
    chk("rst_tmo", 32'(memoryTimeout), 32'd0);
    tick();
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].erd,
            vecs[i].emre, vecs[i].br, vecs[i].busy);
      cyc($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_st);
    end

    // Load-use: one bubble, then the load has moved on
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("lu_stall", STALL, 2'd0);
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    cyc("lu_after", NORM, 2'd0);

    // Branch pulse, FLUSH_CYCLES=3: flush for 3 cycles, states 0,2,2,0
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("br0", FLS, 2'd0);
    branchTaken = 1'b0;
    cyc("br1", FLS, 2'd2);
    cyc("br2", FLS, 2'd2);
    cyc("br3", NORM, 2'd0);

    // Branch re-taken inside FLUSH reloads the counter
    branchTaken = 1'b1;
    cyc("rb0", FLS, 2'd0);
    cyc("rb1", FLS, 2'd2);
    branchTaken = 1'b0;
    cyc("rb2", FLS, 2'd2);
    cyc("rb3", FLS, 2'd2);
    cyc("rb4", NORM, 2'd0);

    // memoryBusy 4 cycles with branch held, branch performed on cycle 5
    branchTaken = 1'b1; memoryBusy = 1'b1;
    cyc("mb0", FRZ, 2'd0);
    cyc("mb1", FRZ, 2'd1);
    cyc("mb2", FRZ, 2'd1);
    cyc("mb3", FRZ, 2'd1);
    memoryBusy = 1'b0;
    cyc("mb4", FLS, 2'd1);
    branchTaken = 1'b0;
    cyc("mb5", FLS, 2'd2);
    cyc("mb6", FLS, 2'd2);
    cyc("mb7", NORM, 2'd0);

    // Timeout: sets after the 255th busy edge, sticky until reset
    memoryBusy = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    @(negedge clock);
    chk("tmo_254", 32'(memoryTimeout), 32'd0);
    tick();
    @(negedge clock);
    chk("tmo_255", 32'(memoryTimeout), 32'd1);
    tick();
    tick();
    memoryBusy = 1'b0;
    tick();
    tick();
    @(negedge clock);
    chk("tmo_sticky", 32'(memoryTimeout), 32'd1);
    chk("tmo_st", 32'(controllerState), 32'd0);

    // Reset mid-FLUSH (counter at 2) aborts and clears the timeout flag
    tick();
    branchTaken = 1'b1;
    cyc("rf_br", FLS, 2'd0);
    branchTaken = 1'b0;
    reset = 1'b1;
    cyc("rf_rst", RST, 2'd2);
    reset = 1'b0;
    cyc("rf_after", NORM, 2'd0);
    @(negedge clock);
    chk("rf_tmo", 32'(memoryTimeout), 32'd0);

`ifdef HAZARD_PERF_COUNTERS_EN
    // Counters: 2 bubbles, 1 branch, 3 busy cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    branchTaken = 1'b0;
    tick();
    tick();
    memoryBusy = 1'b1;
    tick(); tick(); tick();
    memoryBusy = 1'b0;
    tick();
    @(negedge clock);
    chk("perf_bubble", bubbleCount, 32'd2);
    chk("perf_flush", flushCount, 32'd1);
    chk("perf_stall", stallCycles, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
